// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue and the fetch stage.
package instr_prefetch_queue_pkg;

  localparam int unsigned ADDR_W = 16;

  // Also used by the fetch stage's kill path, so keep the value in one place.
  localparam logic [ADDR_W-1:0] NOOP_INSTR = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] instr;
  } q_entry_t;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_fetch_fifo.sv
// DEPTH-entry circular buffer of {addr, instr} pairs with flush and async reset.
module fetch_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  q_entry_t                 push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output q_entry_t                 head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  q_entry_t        mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_eff;

  // A pop against an empty queue is ignored rather than underflowing.
  assign pop_eff = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_eff) begin
      count_d = count_q + CW'(1);
    end else if (!push_i && pop_eff) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        tail_q <= tail_q + PW'(1);
      end
      if (pop_eff) begin
        head_q <= head_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign valid_o      = (count_q != '0);
  assign head_o       = mem_q[head_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: req/ack fetch FSM feeding a small circular queue.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_ack,
  input  logic [ADDR_W-1:0]      imem_rdata,
  input  logic                   consume,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   instr_valid,
  output logic [ADDR_W-1:0]      instr_out,
  output logic [ADDR_W-1:0]      instr_addr_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e      state_q;
  logic              req_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] next_pc_q;

  logic              push, pop, flush;
  q_entry_t          push_data, head;
  logic              fifo_valid;
  logic [CW-1:0]     fifo_count, fifo_count_next;

  // Redirect outranks both the write of a returning word and a consume.
  assign push      = (state_q == ST_WAIT) && imem_ack && !redirect;
  assign pop       = consume;
  assign flush     = redirect;
  assign push_data = '{addr: req_addr_q, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .flush_i      (flush),
    .valid_o      (fifo_valid),
    .head_o       (head),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      next_pc_q  <= RESET_PC;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            next_pc_q <= redirect_pc;
          end else if (fifo_count < DEPTH_C) begin
            state_q    <= ST_WAIT;
            req_q      <= 1'b1;
            req_addr_q <= next_pc_q;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            next_pc_q <= redirect_pc;
            if (imem_ack) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end else begin
              state_q <= ST_DISCARD;
            end
          end else if (imem_ack) begin
            next_pc_q <= addr_inc(req_addr_q);
            // Chain the next sequential request without an idle bubble when room remains.
            if (fifo_count_next < DEPTH_C) begin
              req_addr_q <= addr_inc(req_addr_q);
            end else begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        ST_DISCARD: begin
          if (redirect) begin
            next_pc_q <= redirect_pc;
          end
          if (imem_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = req_addr_q;
  assign instr_valid    = fifo_valid;
  assign instr_out      = fifo_valid ? head.instr : NOOP_INSTR;
  assign instr_addr_out = fifo_valid ? head.addr  : '0;
  assign count          = fifo_count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a latency-programmable memory responder.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        consume;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] instr_addr_out;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  int          mem_lat = 1;
  logic        mem_ovr = 1'b0;
  logic [15:0] mem_ovr_data = 16'h0000;
  int          mcnt = 0;

  instr_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .consume        (consume),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .instr_addr_out (instr_addr_out),
    .count          (count)
  );

  always #5 clk = ~clk;

  // Memory: ack goes high after the request has been seen on mem_lat falling edges.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (imem_ack) begin
        imem_ack = 1'b0;
        mcnt     = 0;
      end
      if (imem_req) begin
        mcnt = mcnt + 1;
        if (mcnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_ovr ? mem_ovr_data : (imem_addr ^ 16'hA500);
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; consume = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_lat = 1; mem_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; consume = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr_out !== 16'hFFFF) begin errors++; $display("FAIL reset_instr got %h exp ffff", instr_out); end
    checks++; if (instr_addr_out !== 16'h0000) begin errors++; $display("FAIL reset_iaddr got %h exp 0000", instr_addr_out); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
  endtask

  task automatic test_fill();
    apply_reset();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL fill_first_req got req=%b addr=%h exp req=1 addr=0000", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fill_no_bypass got valid=%b exp 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_out !== 16'hA500 || instr_addr_out !== 16'h0000) begin errors++; $display("FAIL fill_head got v=%b i=%h a=%h exp v=1 i=a500 a=0000", instr_valid, instr_out, instr_addr_out); end
    checks++; if (count !== 3'd1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL fill_c1 got count=%0d addr=%h exp 1 0001", count, imem_addr); end
    tick();
    checks++; if (count !== 3'd2 || imem_addr !== 16'h0002) begin errors++; $display("FAIL fill_c2 got count=%0d addr=%h exp 2 0002", count, imem_addr); end
    tick();
    checks++; if (count !== 3'd3 || imem_addr !== 16'h0003 || imem_req !== 1'b1) begin errors++; $display("FAIL fill_c3 got count=%0d addr=%h req=%b exp 3 0003 1", count, imem_addr, imem_req); end
    tick();
    checks++; if (count !== 3'd4 || imem_req !== 1'b0) begin errors++; $display("FAIL fill_full got count=%0d req=%b exp 4 0", count, imem_req); end
    tick();
    checks++; if (count !== 3'd4 || imem_req !== 1'b0 || instr_addr_out !== 16'h0000) begin errors++; $display("FAIL fill_hold got count=%0d req=%b a=%h exp 4 0 0000", count, imem_req, instr_addr_out); end
  endtask

  task automatic test_stream();
    apply_reset();
    consume = 1'b1;
    tick();
    checks++; if (count !== 3'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL stream_empty_consume got count=%0d v=%b exp 0 0", count, instr_valid); end
    for (int unsigned k = 2; k < 10; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_addr_out !== 16'(k - 2) || instr_out !== (16'(k - 2) ^ 16'hA500) || count > 3'd2) begin
        errors++;
        $display("FAIL stream_k%0d got v=%b a=%h i=%h count=%0d exp v=1 a=%h count<=2", k, instr_valid, instr_addr_out, instr_out, count, 16'(k - 2));
      end
    end
    consume = 1'b0;
  endtask

  task automatic test_discard();
    apply_reset();
    mem_lat = 3; mem_ovr = 1'b1; mem_ovr_data = 16'h1234;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL disc_req0 got req=%b addr=%h exp 1 0000", imem_req, imem_addr); end
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin errors++; $display("FAIL disc_hold got req=%b addr=%h v=%b exp 1 0000 0", imem_req, imem_addr, instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL disc_wait got v=%b req=%b exp 0 1", instr_valid, imem_req); end
    tick();
    checks++; if (instr_valid !== 1'b0 || instr_out !== 16'hFFFF || imem_req !== 1'b0) begin errors++; $display("FAIL disc_drop got v=%b i=%h req=%b exp 0 ffff 0", instr_valid, instr_out, imem_req); end
    mem_ovr = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL disc_newreq got req=%b addr=%h exp 1 0040", imem_req, imem_addr); end
    repeat (3) tick();
    checks++; if (instr_valid !== 1'b1 || instr_addr_out !== 16'h0040 || instr_out !== 16'hA540) begin errors++; $display("FAIL disc_newdata got v=%b a=%h i=%h exp 1 0040 a540", instr_valid, instr_addr_out, instr_out); end
  endtask

  task automatic test_redirect_ack();
    apply_reset();
    consume = 1'b1;
    repeat (6) tick();
    checks++; if (instr_addr_out !== 16'h0004 || imem_addr !== 16'h0005) begin errors++; $display("FAIL rack_pre got a=%h req_addr=%h exp 0004 0005", instr_addr_out, imem_addr); end
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0; consume = 1'b0;
    checks++; if (instr_valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b0) begin errors++; $display("FAIL rack_flush got v=%b count=%0d req=%b exp 0 0 0", instr_valid, count, imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL rack_newreq got req=%b addr=%h exp 1 0100", imem_req, imem_addr); end
    tick();
    checks++; if (instr_addr_out !== 16'h0100 || instr_out !== 16'hA400 || count !== 3'd1) begin errors++; $display("FAIL rack_newdata got a=%h i=%h count=%0d exp 0100 a400 1", instr_addr_out, instr_out, count); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    repeat (4) tick();
    checks++; if (count !== 3'd3 || imem_addr !== 16'h0003) begin errors++; $display("FAIL b2b_pre got count=%0d addr=%h exp 3 0003", count, imem_addr); end
    consume = 1'b1;
    tick();
    consume = 1'b0;
    checks++; if (count !== 3'd3 || instr_addr_out !== 16'h0001 || imem_req !== 1'b1 || imem_addr !== 16'h0004) begin errors++; $display("FAIL b2b_same got count=%0d a=%h req=%b addr=%h exp 3 0001 1 0004", count, instr_addr_out, imem_req, imem_addr); end
    tick();
    checks++; if (count !== 3'd4 || imem_req !== 1'b0) begin errors++; $display("FAIL b2b_full got count=%0d req=%b exp 4 0", count, imem_req); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3) tick();
    checks++; if (count !== 3'd2 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin errors++; $display("FAIL arst_pre got count=%0d req=%b addr=%h exp 2 1 0002", count, imem_req, imem_addr); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || count !== 3'd0) begin errors++; $display("FAIL arst_ctl got req=%b addr=%h count=%0d exp 0 0000 0", imem_req, imem_addr, count); end
    checks++; if (instr_valid !== 1'b0 || instr_out !== 16'hFFFF || instr_addr_out !== 16'h0000) begin errors++; $display("FAIL arst_head got v=%b i=%h a=%h exp 0 ffff 0000", instr_valid, instr_out, instr_addr_out); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL arst_restart got req=%b addr=%h exp 1 0000", imem_req, imem_addr); end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_idle got req=%b exp 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_req got req=%b addr=%h exp 1 ffff", imem_req, imem_addr); end
    tick();
    checks++; if (imem_addr !== 16'h0000 || instr_addr_out !== 16'hFFFF || instr_out !== 16'h5AFF) begin errors++; $display("FAIL wrap_next got addr=%h a=%h i=%h exp 0000 ffff 5aff", imem_addr, instr_addr_out, instr_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_discard();
    test_redirect_ack();
    test_back_to_back();
    test_async_reset();
    test_pc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Fetch-side block between the instruction memory and the pipeline's fetch stage.
- Issues sequential read requests to a multi-cycle instruction memory over a req/ack handshake.
- Buffers returned words with their addresses in a small circular queue.
- Presents the head instruction to the fetch stage.
- On a control-flow redirect from decode it flushes the queue, discards any in-flight response and restarts at the new PC.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  read request to instruction memory; held high until imem_ack.
- imem_addr  output  16  request address; stable while imem_req is high.
- imem_ack  input  1  one-cycle pulse: imem_rdata is valid this cycle. Ignored when imem_req is low.
- imem_rdata  input  16  returned instruction word.
- consume  input  1  fetch stage takes the head entry this cycle (driven by ~stall).
- redirect  input  1  non-sequential PC change (branch, jump, return, kill).
- redirect_pc  input  16  new fetch address, valid with redirect.
- instr_valid  output  1  queue is non-empty.
- instr_out  output  16  head instruction; 16'hFFFF (NOOP) when empty.
- instr_addr_out  output  16  address of the head instruction; 0 when empty.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values: imem_req=0, imem_addr=0, instr_valid=0, instr_out=16'hFFFF, instr_addr_out=0, count=0. Internally, head=tail=0, next_pc=RESET_PC, state=IDLE.
- States:
  - IDLE: no outstanding request.
  - WAIT: request outstanding; the response will be kept.
  - DISCARD: request outstanding; the response will be dropped.
- imem_req=1 exactly in WAIT and DISCARD. imem_addr is the registered req_addr.
- At most one request is outstanding at any time.
- IDLE:
  - redirect → next_pc=redirect_pc, stay IDLE.
  - else if count<DEPTH → WAIT, req_addr=next_pc.
- WAIT:
  - redirect with no ack → DISCARD; queue flushed; next_pc=redirect_pc.
  - redirect with ack → data dropped; IDLE; queue flushed; next_pc=redirect_pc.
  - ack without redirect → write {req_addr, imem_rdata} at tail; next_pc=req_addr+1 (16-bit wrap, 16'hFFFF→0).
    - Then if count_next<DEPTH, stay WAIT with req_addr=req_addr+1 (back-to-back requests).
    - Otherwise go IDLE.
- DISCARD:
  - ack → drop data, IDLE.
  - redirect → update next_pc, stay.
- Queue rules:
  - count_next = count + write − (consume & instr_valid).
  - consume while empty is ignored.
  - Simultaneous write and consume on a full queue cannot occur, because IDLE launches only when count<DEPTH. Write and consume at count=DEPTH−1 leave count unchanged.
- Redirect flush sets head=tail=count=0 in the same edge. Redirect has priority over consume and over write.
- Latency: an ack in cycle N makes the entry visible in cycle N+1. There is no combinational bypass from imem_rdata to instr_out.
- Head outputs are combinational from registered queue state only.
- Reset asserted mid-request drops imem_req immediately. The instruction memory must tolerate an abandoned request.
- Pointers wrap modulo DEPTH.

Decomposition:
- Shared package/include holds:
  - NOOP_INSTR = 16'hFFFF, shared with the fetch stage's kill path.
  - The state encodings IDLE=2'd0, WAIT=2'd1, DISCARD=2'd2.
  - Address width 16.
- Sub-module: fetch_fifo, a DEPTH×32 circular buffer. It has push, pop, flush, head data, count and async reset.
- The top level holds the request FSM, next_pc and req_addr.

Test Plan:
1. Reset; memory acks 1 cycle after each request with data=addr^16'hA500; consume=0.
   - Requests go to 0,1,2,3; count reaches 4; imem_req falls.
   - instr_out=16'hA500 and instr_addr_out=0 from the cycle after the first ack.
2. Same memory, consume=1 every cycle.
   - Addresses are delivered in order 0,1,2,… with no gaps after warm-up.
   - count never exceeds 2.
3. Memory latency 3 cycles; redirect to 16'h0040 one cycle after request 0 issues; ack arrives with 16'h1234.
   - 16'h1234 is never visible; instr_valid stays 0.
   - The next request address is 16'h0040.
4. Redirect to 16'h0100 in the same cycle as an ack of address 5.
   - Word 5 is dropped; the queue is empty next cycle; the next request is 16'h0100.
5. Queue holds 3 (DEPTH=4); ack and consume in the same cycle.
   - count stays 3; head advances; the request stream continues in WAIT.
6. Assert reset asynchronously between clock edges while in WAIT with count=2.
   - All outputs take their reset values immediately.
   - After release, the first request goes to RESET_PC.
7. Set next_pc to 16'hFFFF via redirect.
   - After the ack, the next request address is 16'h0000.
